seq_stepper: RTL and testbench

Parametrised Mealy-style sequence stepper with a multi-digit 7-segment display. It walks a fixed digit sequence (set by parameter) forward or backward, holds it, or blanks it, under a 2-bit mode select. It steps on an internal clock-enable tick or on a manual step pulse. It sits between board switches/buttons and the seven-segment pins, replacing single-digit, fixed-sequence display FSMs with a derived clock.

---
 rtl/seq_stepper.sv | 152 +++++++++++++++
 tb/tb_seq_stepper.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/seq_stepper.sv
// Sequence stepper driving a multi-digit active-low 7-segment display with a Mealy preview.
// Define SEQ_STEPPER_DBG_EN to expose dbg_idx, dbg_blank and dbg_tick.
module seq_stepper #(
  parameter int LEN     = 9,
  parameter int DIGITS  = 1,
  parameter int DIV_MAX = 50000000,
  parameter logic [LEN*4-1:0] SEQ = {4'd2, 4'd8, 4'd3, 4'd4, 4'd5, 4'd4, 4'd1, 4'd0, 4'd7}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          sel,
  input  logic                step_now,
  output logic [7*DIGITS-1:0] segs
`ifdef SEQ_STEPPER_DBG_EN
  ,
  output logic [3:0]          dbg_idx,
  output logic                dbg_blank,
  output logic                dbg_tick
`endif
);

  localparam int DW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(DIV_MAX - 1);
  localparam logic [3:0]    IDX_LAST = 4'(LEN - 1);

  logic [DW-1:0]       cnt_r;
  logic [3:0]          idx_r;
  logic                blank_r;
  logic                tick_s;
  logic                step_s;
  logic [3:0]          nxt_idx_s;
  logic                nxt_blank_s;
  logic [7*DIGITS-1:0] segs_s;

  function automatic logic [6:0] seg7(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = 7'b0000001;
      4'd1:    pat = 7'b1001111;
      4'd2:    pat = 7'b0010010;
      4'd3:    pat = 7'b0000110;
      4'd4:    pat = 7'b1001100;
      4'd5:    pat = 7'b0100100;
      4'd6:    pat = 7'b0100000;
      4'd7:    pat = 7'b0001111;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0000100;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  // Element 0 sits in the most significant nibble; the offset wraps within LEN.
  function automatic logic [3:0] elem_code(input logic [3:0] base, input int k);
    int e;
    e = (int'(base) + k) % LEN;
    return SEQ[(LEN - 1 - e) * 4 +: 4];
  endfunction

  assign tick_s = (cnt_r == CNT_LAST);
  assign step_s = tick_s | step_now;

  // Step-tick divider, wrapping to zero on the tick cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (tick_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + DW'(1);
    end
  end

  // Next state as selected by sel; doubles as the display preview.
  always_comb begin
    nxt_idx_s   = idx_r;
    nxt_blank_s = blank_r;
    case (sel)
      2'b00: begin
        nxt_idx_s   = idx_r;
        nxt_blank_s = blank_r;
      end
      2'b01: begin
        if (blank_r) begin
          nxt_idx_s   = 4'd0;
          nxt_blank_s = 1'b0;
        end else if (idx_r == 4'd0) begin
          nxt_idx_s   = IDX_LAST;
          nxt_blank_s = 1'b0;
        end else begin
          nxt_idx_s   = idx_r - 4'd1;
          nxt_blank_s = 1'b0;
        end
      end
      2'b10: begin
        if (blank_r) begin
          nxt_idx_s   = 4'd0;
          nxt_blank_s = 1'b0;
        end else if (idx_r == IDX_LAST) begin
          nxt_idx_s   = 4'd0;
          nxt_blank_s = 1'b0;
        end else begin
          nxt_idx_s   = idx_r + 4'd1;
          nxt_blank_s = 1'b0;
        end
      end
      2'b11: begin
        nxt_idx_s   = idx_r;
        nxt_blank_s = 1'b1;
      end
      default: begin
        nxt_idx_s   = idx_r;
        nxt_blank_s = blank_r;
      end
    endcase
  end

  // Sequence state register, advanced only on a step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_r   <= 4'd0;
      blank_r <= 1'b0;
    end else if (step_s) begin
      idx_r   <= nxt_idx_s;
      blank_r <= nxt_blank_s;
    end else begin
      idx_r   <= idx_r;
      blank_r <= blank_r;
    end
  end

  // Segment patterns for every digit of the previewed state.
  always_comb begin
    segs_s = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (nxt_blank_s) begin
        segs_s[7*k +: 7] = 7'b1111111;
      end else begin
        segs_s[7*k +: 7] = seg7(elem_code(nxt_idx_s, k));
      end
    end
  end

  assign segs = segs_s;

`ifdef SEQ_STEPPER_DBG_EN
  assign dbg_idx   = idx_r;
  assign dbg_blank = blank_r;
  assign dbg_tick  = tick_s;
`endif

endmodule

// File: tb/tb_seq_stepper.sv
// Randomised bench for seq_stepper with a behavioural model and literal anchor checks.
module tb_seq_stepper;

  localparam int LEN     = 9;
  localparam int DIGITS  = 2;
  localparam int DIV_MAX = 4;
  localparam logic [13:0] RST_DISP = 14'b0000000_0010010;
  localparam logic [13:0] UP1_DISP = 14'b0000110_0000000;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic [1:0]  sel      = 2'b00;
  logic        step_now = 1'b0;
  logic [13:0] segs;

  int checks = 0;
  int errors = 0;

  int m_idx   = 0;
  bit m_blank = 1'b0;
  int m_cyc   = 0;

  int         seq_t[LEN] = '{2, 8, 3, 4, 5, 4, 1, 0, 7};
  logic [6:0] seg_t[10]  = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  seq_stepper #(.LEN(LEN), .DIGITS(DIGITS), .DIV_MAX(DIV_MAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .step_now (step_now),
    .segs     (segs)
  );

  always #5 clk = ~clk;

  // Returns blank*16 + idx of the state a step would produce.
  function automatic int next_of(int idx, bit blank, logic [1:0] s);
    int b;
    b = blank ? 1 : 0;
    case (s)
      2'b00:   return b * 16 + idx;
      2'b01:   return blank ? 0 : (idx + LEN - 1) % LEN;
      2'b10:   return blank ? 0 : (idx + 1) % LEN;
      default: return 16 + idx;
    endcase
  endfunction

  function automatic logic [13:0] disp(int idx, bit blank, logic [1:0] s);
    int n;
    int code;
    logic [13:0] r;
    n = next_of(idx, blank, s);
    r = '1;
    if (n < 16) begin
      for (int k = 0; k < DIGITS; k++) begin
        code = seq_t[(n + k) % LEN];
        r[7*k +: 7] = (code < 10) ? seg_t[code] : 7'b1111111;
      end
    end
    return r;
  endfunction

  task automatic check(string name, logic [13:0] act, logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference state: cycle count since release, step on tick or manual request.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_idx   <= 0;
      m_blank <= 1'b0;
      m_cyc   <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (((m_cyc % DIV_MAX) == DIV_MAX - 1) || step_now) begin
        m_idx   <= next_of(m_idx, m_blank, sel) % 16;
        m_blank <= (next_of(m_idx, m_blank, sel) >= 16);
      end
    end
  end

  always @(negedge clk) begin
    check("segs_model", segs, disp(m_idx, m_blank, sel));
  end

  initial begin
    #1 rst = 1'b0;
    #2 check("reset_disp", segs, RST_DISP);
    cyc(1);
    rst = 1'b1;
    cyc(20);
    check("hold_20", segs, RST_DISP);

    sel = 2'b10;
    #1 check("up_preview", segs, UP1_DISP);
    cyc(40);

    rst = 1'b0;
    sel = 2'b01;
    #1 check("down_preview", segs, 14'b0010010_0001111);
    cyc(1);
    rst = 1'b1;
    cyc(3);
    check("down_pretick", segs, 14'b0010010_0001111);
    cyc(1);
    check("down_tick", segs, 14'b0001111_0000001);

    sel = 2'b11;
    #1 check("blank_preview", segs, 14'b1111111_1111111);
    cyc(4);
    sel = 2'b10;
    #1 check("unblank_preview", segs, RST_DISP);
    cyc(6);

    rst = 1'b0;
    sel = 2'b10;
    cyc(1);
    rst = 1'b1;
    step_now = 1'b1;
    cyc(5);
    step_now = 1'b0;
    sel = 2'b00;
    #1 check("idx5_hold", segs, 14'b1001111_1001100);
    rst = 1'b0;
    #1 check("async_reset", segs, RST_DISP);
    cyc(1);
    rst = 1'b1;
    sel = 2'b10;
    cyc(3);
    check("release_pretick", segs, UP1_DISP);
    cyc(1);
    check("release_tick", segs, 14'b1001100_0000110);

    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) sel = 2'($urandom_range(0, 3));
      step_now = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 199) != 0);
      cyc(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
